// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM state type, BCD digit limits and BCD increment helper
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam logic [3:0] UNITS_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX  = 4'd5;

   // Returns {carry_out, incremented MM:SS}; carry_out marks the 59:59 -> 00:00 roll.
   function automatic logic [16:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      logic [3:0]  lim;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lim = ((i % 2) == 0) ? UNITS_MAX : TENS_MAX;
         if (c) begin
            if (r[i*4 +: 4] == lim) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return {c, r};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - one-second prescaler: counts 0..ONE_SECOND-1 while enabled, pulses tick at the top
module tick_gen #(
   parameter int ONE_SECOND = 50000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int           W     = (ONE_SECOND > 1) ? $clog2(ONE_SECOND) : 1;
   localparam logic [W-1:0] MAX_C = W'(ONE_SECOND - 1);
   localparam logic [W-1:0] ONE_C = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign tick_o = en_i && (count_q == MAX_C);

   // clear outranks enable; with neither asserted the count is held
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tick_o ? '0 : count_q + ONE_C;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS stopwatch with start/stop and clear keys
// Optional lap-freeze display on clear-in-RUN when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int ONE_SECOND = 50000000
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        key_start_n,
   input  logic        key_clear_n,
   output logic [15:0] bcd,
   output logic        running,
   output logic        tick,
   output logic        wrap
);

   sw_state_t   state_q, state_d;
   logic        start_meta_q, start_sync_q, start_prev_q;
   logic        clear_meta_q, clear_sync_q, clear_prev_q;
   logic        start_pulse, clear_pulse;
   logic [15:0] cnt_q, cnt_d;
   logic        wrap_q;
   logic [16:0] inc;

   // synchronizer and edge flops idle high so a released key never pulses
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         start_meta_q <= 1'b1;
         start_sync_q <= 1'b1;
         start_prev_q <= 1'b1;
         clear_meta_q <= 1'b1;
         clear_sync_q <= 1'b1;
         clear_prev_q <= 1'b1;
      end else begin
         start_meta_q <= key_start_n;
         start_sync_q <= start_meta_q;
         start_prev_q <= start_sync_q;
         clear_meta_q <= key_clear_n;
         clear_sync_q <= clear_meta_q;
         clear_prev_q <= clear_sync_q;
      end
   end

   assign start_pulse = start_prev_q & ~start_sync_q;
   assign clear_pulse = clear_prev_q & ~clear_sync_q;

`ifdef STOPWATCH_LAP_EN
   logic lap_tgl;
`endif

   always_comb begin
      state_d = state_q;
`ifdef STOPWATCH_LAP_EN
      lap_tgl = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (!clear_pulse && start_pulse) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_pulse) begin
               state_d = ST_PAUSE;
            end
`ifdef STOPWATCH_LAP_EN
            else if (clear_pulse) begin
               lap_tgl = 1'b1;
            end
`endif
         end
         ST_PAUSE: begin
            if (clear_pulse)      state_d = ST_IDLE;
            else if (start_pulse) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   tick_gen #(
      .ONE_SECOND(ONE_SECOND)
   ) u_tick_gen (
      .clk_i  (CLOCK_50),
      .rst_ni (reset_n),
      .en_i   (state_q == ST_RUN),
      .clr_i  (state_d == ST_IDLE),
      .tick_o (tick)
   );

   assign inc = bcd_inc(cnt_q);

   // IDLE always shows 00:00, so entering or staying in IDLE doubles as the clear
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == ST_IDLE) cnt_d = 16'h0000;
      else if (tick)          cnt_d = inc[15:0];
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'h0000;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= tick & inc[16];
      end
   end

   assign running = (state_q == ST_RUN);
   assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
   logic        lap_q, lap_d;
   logic [15:0] lap_bcd_q, lap_bcd_d;

   // any start pulse or a return to IDLE drops the frozen lap view
   always_comb begin
      lap_d     = lap_tgl ? ~lap_q : lap_q;
      lap_bcd_d = (lap_tgl && !lap_q) ? cnt_q : lap_bcd_q;
      if (start_pulse || state_d == ST_IDLE) lap_d = 1'b0;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         lap_q     <= 1'b0;
         lap_bcd_q <= 16'h0000;
      end else begin
         lap_q     <= lap_d;
         lap_bcd_q <= lap_bcd_d;
      end
   end

   assign bcd = lap_q ? lap_bcd_q : cnt_q;
`else
   assign bcd = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with a seconds-based reference model
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

   localparam int OS = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        key_start_n;
   logic        key_clear_n;
   logic [15:0] bcd;
   logic        running;
   logic        tick;
   logic        wrap;

   stopwatch_ctrl #(.ONE_SECOND(OS)) dut (
      .CLOCK_50    (clk),
      .reset_n     (reset_n),
      .key_start_n (key_start_n),
      .key_clear_n (key_clear_n),
      .bcd         (bcd),
      .running     (running),
      .tick        (tick),
      .wrap        (wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        running;
      logic        tick;
      logic        wrap;
      logic [15:0] bcd;
   } snap_t;

   typedef struct {
      int edge_n;
      bit s;
      bit c;
   } ev_t;

   snap_t exp_q[$];
   ev_t   ev_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    m_wraps = 0;
   int    d_wraps = 0;

   // model: 0 idle, 1 run, 2 pause; time kept as whole seconds
   int m_st = 0, m_pre = 0, m_sec = 0, m_frz = 0;
   bit m_lap = 0, m_wrap = 0;

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   always @(posedge clk) begin
      bit s, c, fire;
      int old_sec;
      snap_t e;
      cyc++;
      s = 0;
      c = 0;
      while (ev_q.size() > 0 && ev_q[0].edge_n <= cyc) begin
         if (ev_q[0].edge_n == cyc) begin
            s |= ev_q[0].s;
            c |= ev_q[0].c;
         end
         void'(ev_q.pop_front());
      end
      if (!reset_n) begin
         m_st = 0; m_pre = 0; m_sec = 0; m_frz = 0; m_lap = 0; m_wrap = 0;
      end else begin
         old_sec = m_sec;
         fire    = (m_st == 1 && m_pre == OS - 1);
         m_wrap  = 0;
         if (m_st == 1) m_pre = (m_pre + 1) % OS;
         if (fire) begin
            m_sec  = (m_sec + 1) % 3600;
            m_wrap = (m_sec == 0);
            if (m_wrap) m_wraps++;
         end
         case (m_st)
            0: if (!c && s) m_st = 1;
            1: begin
               if (s) begin
                  m_st  = 2;
                  m_lap = 0;
               end
`ifdef STOPWATCH_LAP_EN
               else if (c) begin
                  if (!m_lap) m_frz = old_sec;
                  m_lap = !m_lap;
               end
`endif
            end
            default: begin
               if (c)      m_st = 0;
               else if (s) m_st = 1;
            end
         endcase
         if (m_st == 0) begin
            m_pre = 0; m_sec = 0; m_lap = 0;
         end
      end
      e.running = (m_st == 1);
      e.tick    = (m_st == 1 && m_pre == OS - 1);
      e.wrap    = m_wrap;
      e.bcd     = m_lap ? to_bcd(m_frz) : to_bcd(m_sec);
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      snap_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!reset_n) e = '0;
         a.running = running;
         a.tick    = tick;
         a.wrap    = wrap;
         a.bcd     = bcd;
         if (wrap === 1'b1) d_wraps++;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle %0d snapshot: got run=%b tick=%b wrap=%b bcd=%h, expected run=%b tick=%b wrap=%b bcd=%h",
                     cyc, a.running, a.tick, a.wrap, a.bcd, e.running, e.tick, e.wrap, e.bcd);
         end
      end
   end

   task automatic press(input bit s, input bit c, input int hold);
      ev_t ev;
      @(posedge clk);
      #2;
      if (s) key_start_n = 1'b0;
      if (c) key_clear_n = 1'b0;
      ev.edge_n = cyc + 3;
      ev.s      = s;
      ev.c      = c;
      ev_q.push_back(ev);
      repeat (hold) @(posedge clk);
      #2;
      key_start_n = 1'b1;
      key_clear_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   p, seen, r;
      ev_t  ev;
      reset_n     = 1'b0;
      key_start_n = 1'b1;
      key_clear_n = 1'b1;
      idle(3);
      #2 reset_n = 1'b1;
      idle(4);

      // start key latency: running must rise on the third edge after the press
      @(posedge clk);
      #2;
      key_start_n = 1'b0;
      p = cyc;
      ev.edge_n = p + 3; ev.s = 1; ev.c = 0;
      ev_q.push_back(ev);
      seen = -1;
      for (int i = 0; i < 10 && seen < 0; i++) begin
         @(negedge clk);
         if (running === 1'b1) seen = cyc;
      end
      #1 key_start_n = 1'b1;
      checks++;
      if (seen != p + 3) begin
         errors++;
         $display("FAIL start_latency: running rose at edge %0d, expected edge %0d", seen, p + 3);
      end
      idle(20);

      // pause a few cycles into a second, hold, resume
      press(1, 0, 2); idle(7);
      press(1, 0, 1); idle(9);
      // clear from pause, then start/pause six cycles apart
      press(1, 0, 1); idle(4);
      press(0, 1, 1); idle(5);
      press(1, 0, 1); idle(4);
      press(1, 0, 1); idle(10);
      press(1, 0, 1); idle(12);
      // simultaneous start+clear in pause
      press(1, 0, 1); idle(5);
      press(1, 1, 2); idle(8);
      // long hold gives one state change only
      press(1, 0, 100); idle(10);
      press(1, 1, 1); idle(6);
      press(0, 1, 1); idle(6);

      // lap-style clear in RUN around 00:03, then again five seconds later
      press(1, 0, 1); idle(11);
      press(0, 1, 1); idle(19);
      press(0, 1, 1); idle(10);
      press(1, 0, 1); idle(4);
      press(0, 1, 1); idle(5);

      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: press(1, 0, $urandom_range(1, 6));
            1: press(0, 1, $urandom_range(1, 6));
            2: press(1, 1, $urandom_range(1, 6));
            default: press(1, 0, $urandom_range(20, 40));
         endcase
         idle($urandom_range(3, 20));
      end

      // back to IDLE, then count through 59:59 -> 00:00
      press(1, 0, 1); idle(4);
      if (m_st == 1) begin
         press(1, 0, 1); idle(4);
      end
      press(0, 1, 1); idle(4);
      press(1, 0, 1);
      idle(3600 * OS + 40);

      // asynchronous reset in the middle of a run
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({running, tick, wrap, bcd} !== 19'd0) begin
         errors++;
         $display("FAIL async_reset: got run=%b tick=%b wrap=%b bcd=%h, expected all zero",
                  running, tick, wrap, bcd);
      end
      idle(3);
      #2 reset_n = 1'b1;
      idle(10);
      press(1, 0, 1); idle(30);

      checks++;
      if (m_wraps < 1 || d_wraps != m_wraps) begin
         errors++;
         $display("FAIL wrap_count: got %0d wrap pulses, expected %0d (at least 1)", d_wraps, m_wraps);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
